sum_display_mux: RTL
====================

Name: sum_display_mux

Overview:
- Downstream consumer of the 4-bit ripple-carry adder; sits between the adder outputs and the board's two-digit 7-segment display.
- On a load strobe, captures the 5-bit result {carry, sum[3:0]} (0..31).
- Converts it to two BCD digits with an iterative double-dabble FSM.
- Time-multiplexes the two digits onto one shared segment bus, with a refresh counter.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays lit before the anode select toggles (>=2)
SEG_ACTIVE_LOW, 1, 1 = out_seg and out_an active-low; 0 = active-high

Ports:
in_clk  input  1  system clock
in_rst  input  1  synchronous reset, active-high
in_s    input  4  adder sum bits s3..s0
in_cy   input  1  adder carry-out
in_load  input  1  capture request, sampled on rising in_clk
out_busy  output  1  high while a conversion is in progress
out_seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}
out_an  output  2  digit enables; bit0 = units, bit1 = tens

Behaviour:
- Interface: one clock, in_clk. in_rst is synchronous and active-high; all state updates on the rising edge of in_clk only.
- Reset values:
  - FSM in IDLE, out_busy=0, shift/BCD registers=0.
  - Display registers tens=0, units=0.
  - Refresh counter=0, digit select=units.
  - Hence out_an selects units (2'b10 when active-low); out_seg shows "0" (7'b1000000 when active-low).
- FSM states IDLE, CONV:
  - IDLE: in_load=1 at edge k loads bin={in_cy,in_s} and clears BCD=0, iter=0, then goes to CONV. out_busy=1 from after edge k.
  - CONV, one iteration per cycle:
    - Add 3 to each BCD nibble that is >=5.
    - Shift {BCD,bin} left by 1.
    - iter++.
  - After the 5th iteration (edge k+5), copy BCD into the tens/units display registers, return to IDLE, out_busy=0 after edge k+5.
- Latency: the new value is displayed 5 cycles after load; busy is high for exactly 5 cycles.
- in_load while busy is ignored; there is no queueing.
- in_load held high in IDLE restarts a conversion on each IDLE cycle with the current inputs.
- Display registers keep the previous value for the whole conversion; no intermediate values are ever shown.
- Refresh:
  - Counter counts 0..REFRESH_DIV-1.
  - On the terminal count: wrap to 0 and toggle digit select.
  - Runs independently of the FSM.
- Output decode: out_an is one-hot of the selected digit; out_seg is the 7-segment decode of the selected register. Both are combinational from registered state.
- Leading-zero blanking: when tens=0 and tens is selected, all segments are off.
- Polarity: SEG_ACTIVE_LOW inverts both out_seg and out_an.
- Reset mid-conversion aborts the conversion; all registers return to their reset values.

Optional Feature:
SUM_DISP_HEX_EN
- Defined:
  - Double-dabble is bypassed. On in_load, units=in_s (hex 0-F) and tens={3'b0,in_cy}; registers update at the next edge.
  - out_busy is never asserted; the FSM stays in IDLE.
  - Blanking applies when in_cy=0. Decode covers 0-9 and A-F (A,b,C,d,E,F).
- Undefined: decimal behaviour as specified above.

Test Plan:
- Reset state: assert in_rst 2 cycles -> out_busy=0, out_an=2'b10, out_seg=7'b1000000.
- Full-scale value (REFRESH_DIV=4, active-low): in_s=4'hF, in_cy=1, pulse in_load -> out_busy=1 for 5 cycles, then an alternating sequence every 4 cycles:
  - out_an=2'b01 with out_seg=7'b0110000 ("3").
  - out_an=2'b10 with out_seg=7'b1111001 ("1").
- Blanking: load 9 (in_s=4'h9, in_cy=0) -> units out_seg=7'b0010000; tens slot out_seg=7'b1111111.
- Load while busy: load 31, then load 0 two cycles later -> busy stays 5 cycles total; display shows 31.
- Reset mid-conversion: load 31, assert in_rst on cycle 3 -> out_busy=0; display shows blank tens and "0" units.
- With SUM_DISP_HEX_EN defined: load in_s=4'hF, in_cy=1 -> out_busy stays 0; next cycle units=F (7'b0001110) and tens=1 (7'b1111001).

Source files
------------

// File: rtl/sum_display_mux.sv
// sum_display_mux: captures {carry,sum}, converts to two BCD digits by double-dabble, and multiplexes them onto a shared 7-segment bus; define SUM_DISP_HEX_EN for direct hex display
module sum_display_mux #(
   parameter int REFRESH_DIV    = 50000,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic       in_clk,
   input  logic       in_rst,
   input  logic [3:0] in_s,
   input  logic       in_cy,
   input  logic       in_load,
   output logic       out_busy,
   output logic [6:0] out_seg,
   output logic [1:0] out_an
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic INV = (SEG_ACTIVE_LOW != 0);

   typedef enum logic {IDLE, CONV} state_t;

   state_t state, state_nxt;
   logic [4:0] bin;
   logic [7:0] bcd;
   logic [7:0] bcd_adj;
   logic [2:0] iter;
   logic [3:0] tens, units, digit;
   logic [CW-1:0] cnt;
   logic sel;
   logic blank;
   logic [6:0] seg_raw;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   assign bcd_adj  = {add3(bcd[7:4]), add3(bcd[3:0])};
   assign out_busy = (state == CONV);

   // next state: a load in IDLE starts a conversion that ends after five iterations
   always_comb begin
      state_nxt = state;
`ifdef SUM_DISP_HEX_EN
      state_nxt = IDLE;
`else
      if (state == IDLE)
         state_nxt = in_load ? CONV : IDLE;
      else
         state_nxt = (iter == 3'd4) ? IDLE : CONV;
`endif
   end

   // state register
   always_ff @(posedge in_clk)
      state <= in_rst ? IDLE : state_nxt;

   // conversion datapath and display registers; display only changes on the final iteration
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         bin   <= '0;
         bcd   <= '0;
         iter  <= '0;
         tens  <= '0;
         units <= '0;
      end else if (state == IDLE) begin
         if (in_load) begin
`ifdef SUM_DISP_HEX_EN
            units <= in_s;
            tens  <= {3'b000, in_cy};
`else
            bin  <= {in_cy, in_s};
            bcd  <= '0;
            iter <= '0;
`endif
         end
      end else begin
         bcd  <= {bcd_adj[6:0], bin[4]};
         bin  <= {bin[3:0], 1'b0};
         iter <= iter + 3'd1;
         if (iter == 3'd4) begin
            tens  <= bcd_adj[6:3];
            units <= {bcd_adj[2:0], bin[4]};
         end
      end
   end

   // refresh counter toggles the digit select every REFRESH_DIV cycles
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         cnt <= '0;
         sel <= 1'b0;
      end else if (cnt == CW'(REFRESH_DIV - 1)) begin
         cnt <= '0;
         sel <= ~sel;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // segment decode of the selected digit with leading-zero blanking and polarity
   always_comb begin
      digit = sel ? tens : units;
      blank = sel && (tens == 4'd0);
      seg_raw = 7'h00;
      case (digit)
         4'h0: seg_raw = 7'h3F;
         4'h1: seg_raw = 7'h06;
         4'h2: seg_raw = 7'h5B;
         4'h3: seg_raw = 7'h4F;
         4'h4: seg_raw = 7'h66;
         4'h5: seg_raw = 7'h6D;
         4'h6: seg_raw = 7'h7D;
         4'h7: seg_raw = 7'h07;
         4'h8: seg_raw = 7'h7F;
         4'h9: seg_raw = 7'h6F;
         4'hA: seg_raw = 7'h77;
         4'hB: seg_raw = 7'h7C;
         4'hC: seg_raw = 7'h39;
         4'hD: seg_raw = 7'h5E;
         4'hE: seg_raw = 7'h79;
         default: seg_raw = 7'h71;
      endcase
      out_seg = (blank ? 7'h00 : seg_raw) ^ {7{INV}};
      out_an  = (sel ? 2'b10 : 2'b01) ^ {2{INV}};
   end
endmodule
